// File: rtl/cnn_pkg.sv
// cnn_pkg: shared FSM states, width defaults and clog2 for the CNN stages
package cnn_pkg;
  localparam int DEF_FEAT_W   = 24;
  localparam int DEF_WEIGHT_W = 8;
  localparam int DEF_ACC_W    = 40;
  typedef enum logic [2:0] {IDLE, FETCH, DRAIN, CMP, DONE} state_e;
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction
endpackage

// File: rtl/argmax_tracker.sv
// argmax_tracker: running maximum with lowest-index-wins tie rule
module argmax_tracker #(
  parameter int ACC_W = 40,
  parameter int CLS_W = 2
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    clr,
  input  logic                    cmp_en,
  input  logic signed [ACC_W-1:0] score,
  input  logic [CLS_W-1:0]        idx,
  output logic signed [ACC_W-1:0] best_score,
  output logic [CLS_W-1:0]        best_idx,
  output logic                    best_valid
);
  logic signed [ACC_W-1:0] best_d;
  logic [CLS_W-1:0] idx_d;
  logic valid_d, upd;
  // strict greater-than keeps the earlier (lower) index on ties
  always_comb begin
    upd     = cmp_en && (!best_valid || score > best_score);
    best_d  = clr ? '0 : upd ? score : best_score;
    idx_d   = clr ? '0 : upd ? idx : best_idx;
    valid_d = clr ? 1'b0 : (best_valid || upd);
  end
  // tracker state register
  always_ff @(posedge clk) begin
    if (rst) begin
      best_score <= '0;
      best_idx   <= '0;
      best_valid <= 1'b0;
    end else begin
      best_score <= best_d;
      best_idx   <= idx_d;
      best_valid <= valid_d;
    end
  end
endmodule

// File: rtl/dense_argmax_engine.sv
// dense_argmax_engine: per-class dot product over BRAM features/weights with argmax
module dense_argmax_engine
  import cnn_pkg::*;
#(
  parameter int IN_FEATURES = 6,
  parameter int NUM_CLASSES = 3,
  parameter int FEAT_W      = DEF_FEAT_W,
  parameter int WEIGHT_W    = DEF_WEIGHT_W,
  parameter int USE_BIAS    = 0,
  parameter int ACC_W       = DEF_ACC_W,
  parameter int FEAT_AW     = 5,
  parameter int W_AW        = 6,
  parameter int CLS_W       = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  output logic                busy,
  output logic                done,
  output logic                feat_rd_en,
  output logic [FEAT_AW-1:0]  feat_rd_addr,
  input  logic [FEAT_W-1:0]   feat_rd_data,
  output logic                w_rd_en,
  output logic [W_AW-1:0]     w_rd_addr,
  input  logic [WEIGHT_W-1:0] w_rd_data,
  output logic [CLS_W-1:0]    class_out,
  output logic [ACC_W-1:0]    max_score
);
  localparam int K_W    = clog2(IN_FEATURES + 1);
  localparam int LAST_K = IN_FEATURES - 1 + USE_BIAS;
  state_e state_q, state_d;
  logic [K_W-1:0] k_q, k_d;
  logic [CLS_W-1:0] c_q, c_d, cls_q, cls_d, best_idx;
  logic [W_AW-1:0] base_q, base_d;
  logic signed [ACC_W-1:0] acc_q, acc_d, max_q, max_d, best_score, prod_x, bias_x;
  logic signed [FEAT_W+WEIGHT_W-1:0] prod;
  logic mac_q, mac_d, bias_q, bias_d, done_q, done_d, busy_q, busy_d;
  logic fetch, is_bias, clr, cmp_en, best_valid;
  assign prod   = $signed(feat_rd_data) * $signed(w_rd_data);
  assign prod_x = ACC_W'(prod);
  assign bias_x = ACC_W'($signed(w_rd_data));
  // sequencing, BRAM addressing and MAC accumulate one cycle behind the read issue
  always_comb begin
    fetch        = state_q == FETCH;
    is_bias      = USE_BIAS != 0 && k_q == K_W'(IN_FEATURES);
    feat_rd_en   = fetch && !is_bias;
    w_rd_en      = fetch;
    feat_rd_addr = FEAT_AW'(k_q);
    w_rd_addr    = is_bias ? W_AW'(NUM_CLASSES * IN_FEATURES) + W_AW'(c_q) : base_q + W_AW'(k_q);
    mac_d        = feat_rd_en;
    bias_d       = fetch && is_bias;
    acc_d        = acc_q + (mac_q ? prod_x : bias_q ? bias_x : '0);
    state_d      = state_q;
    k_d          = k_q;
    c_d          = c_q;
    base_d       = base_q;
    cls_d        = cls_q;
    max_d        = max_q;
    done_d       = 1'b0;
    clr          = 1'b0;
    cmp_en       = 1'b0;
    case (state_q)
      IDLE: if (start) begin
        state_d = FETCH;
        k_d     = '0;
        c_d     = '0;
        base_d  = '0;
        acc_d   = '0;
        clr     = 1'b1;
      end
      FETCH: begin
        k_d     = k_q + 1'b1;
        state_d = k_q == K_W'(LAST_K) ? DRAIN : FETCH;
      end
      DRAIN: state_d = CMP;
      CMP: begin
        cmp_en = 1'b1;
        acc_d  = '0;
        k_d    = '0;
        if (c_q == CLS_W'(NUM_CLASSES - 1)) state_d = DONE;
        else begin
          c_d     = c_q + 1'b1;
          base_d  = base_q + W_AW'(IN_FEATURES);
          state_d = FETCH;
        end
      end
      DONE: begin
        done_d  = 1'b1;
        cls_d   = best_idx;
        max_d   = best_score;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
    busy_d = state_d != IDLE;
  end
  // state and datapath registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      k_q     <= '0;
      c_q     <= '0;
      base_q  <= '0;
      acc_q   <= '0;
      max_q   <= '0;
      cls_q   <= '0;
      mac_q   <= 1'b0;
      bias_q  <= 1'b0;
      done_q  <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      k_q     <= k_d;
      c_q     <= c_d;
      base_q  <= base_d;
      acc_q   <= acc_d;
      max_q   <= max_d;
      cls_q   <= cls_d;
      mac_q   <= mac_d;
      bias_q  <= bias_d;
      done_q  <= done_d;
      busy_q  <= busy_d;
    end
  end
  argmax_tracker #(.ACC_W(ACC_W), .CLS_W(CLS_W)) u_track (
    .clk(clk), .rst(rst), .clr(clr), .cmp_en(cmp_en), .score(acc_q), .idx(c_q),
    .best_score(best_score), .best_idx(best_idx), .best_valid(best_valid)
  );
  assign busy      = busy_q;
  assign done      = done_q;
  assign class_out = cls_q;
  assign max_score = max_q;
endmodule

// File: tb/tb_dense_argmax_engine.sv
// tb_dense_argmax_engine: directed checks of dense_argmax_engine with and without bias
module tb_dense_argmax_engine;
  logic clk = 1'b0, rst = 1'b1, start_a = 1'b0, start_b = 1'b0;
  logic busy_a, done_a, fe_a, we_a, busy_b, done_b, fe_b, we_b;
  logic [4:0] fa_a, fa_b;
  logic [5:0] wa_a, wa_b;
  logic [23:0] fd_a, fd_b;
  logic [7:0] wd_a, wd_b;
  logic [1:0] cls_a, cls_b;
  logic [39:0] max_a, max_b;
  logic [23:0] feat_mem [0:31];
  logic [7:0] w_mem [0:63];
  int n_checks = 0, n_fail = 0;
  int addr_log[$];
  always #5 clk = ~clk;
  always @(posedge clk) begin
    if (fe_a) fd_a <= feat_mem[fa_a];
    if (we_a) wd_a <= w_mem[wa_a];
    if (fe_b) fd_b <= feat_mem[fa_b];
    if (we_b) wd_b <= w_mem[wa_b];
  end
  dense_argmax_engine dut_a (
    .clk(clk), .rst(rst), .start(start_a), .busy(busy_a), .done(done_a),
    .feat_rd_en(fe_a), .feat_rd_addr(fa_a), .feat_rd_data(fd_a),
    .w_rd_en(we_a), .w_rd_addr(wa_a), .w_rd_data(wd_a),
    .class_out(cls_a), .max_score(max_a)
  );
  dense_argmax_engine #(.USE_BIAS(1)) dut_b (
    .clk(clk), .rst(rst), .start(start_b), .busy(busy_b), .done(done_b),
    .feat_rd_en(fe_b), .feat_rd_addr(fa_b), .feat_rd_data(fd_b),
    .w_rd_en(we_b), .w_rd_addr(wa_b), .w_rd_data(wd_b),
    .class_out(cls_b), .max_score(max_b)
  );

  task automatic load(input int w0, input int w1, input int w2, input int b0, input int b1, input int b2);
    for (int k = 0; k < 32; k++) feat_mem[k] = (k < 6) ? 24'd4 : 24'd0;
    for (int k = 0; k < 64; k++) w_mem[k] = 8'd0;
    for (int k = 0; k < 6; k++) begin
      w_mem[k]      = 8'(w0);
      w_mem[6 + k]  = 8'(w1);
      w_mem[12 + k] = 8'(w2);
    end
    w_mem[18] = 8'(b0);
    w_mem[19] = 8'(b1);
    w_mem[20] = 8'(b2);
  endtask

  task automatic run(input string name, input bit b, input int exp_cls, input int exp_score,
                     input int exp_lat, input int restart_at);
    int m;
    bit seen;
    addr_log.delete();
    @(negedge clk);
    if (b) start_b = 1'b1; else start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    start_b = 1'b0;
    m = 0;
    seen = 1'b0;
    while (!seen && m < 100) begin
      if (!b && we_a) addr_log.push_back(int'(wa_a));
      if (b && we_b) addr_log.push_back(int'(wa_b));
      if (restart_at != 0 && m == restart_at) begin
        if (b) start_b = 1'b1; else start_a = 1'b1;
      end
      @(negedge clk);
      start_a = 1'b0;
      start_b = 1'b0;
      m++;
      if (m == 1) begin
        n_checks++;
        if ((b ? busy_b : busy_a) !== 1'b1) begin
          n_fail++;
          $display("FAIL %s busy: got %b want 1", name, b ? busy_b : busy_a);
        end
      end
      seen = b ? done_b : done_a;
    end
    n_checks++;
    if (m != exp_lat) begin
      n_fail++;
      $display("FAIL %s latency: got %0d want %0d", name, m, exp_lat);
    end
    n_checks++;
    if ((b ? cls_b : cls_a) !== 2'(exp_cls)) begin
      n_fail++;
      $display("FAIL %s class_out: got %0d want %0d", name, b ? cls_b : cls_a, exp_cls);
    end
    n_checks++;
    if ((b ? max_b : max_a) !== 40'(exp_score)) begin
      n_fail++;
      $display("FAIL %s max_score: got %0d want %0d", name, $signed(b ? max_b : max_a), exp_score);
    end
    @(negedge clk);
    n_checks++;
    if ((b ? done_b : done_a) !== 1'b0 || (b ? busy_b : busy_a) !== 1'b0) begin
      n_fail++;
      $display("FAIL %s done/busy after pulse: got %b%b want 00", name,
               b ? done_b : done_a, b ? busy_b : busy_a);
    end
  endtask

  task automatic check_idle_zero(input string name);
    n_checks++;
    if ({busy_a, done_a, fe_a, we_a, fa_a, wa_a, cls_a, max_a} !== '0) begin
      n_fail++;
      $display("FAIL %s: got busy=%b done=%b fe=%b we=%b fa=%0d wa=%0d cls=%0d max=%0d want all 0",
               name, busy_a, done_a, fe_a, we_a, fa_a, wa_a, cls_a, max_a);
    end
  endtask

  task automatic test_reset();
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("reset_state");
    n_checks++;
    if ({busy_b, done_b, cls_b, max_b} !== '0) begin
      n_fail++;
      $display("FAIL reset_state_bias: got busy=%b done=%b cls=%0d max=%0d want 0", busy_b, done_b, cls_b, max_b);
    end
  endtask

  task automatic test_argmax();
    load(5, 1, 1, 0, 0, 0);
    run("class0", 1'b0, 0, 120, 25, 0);
    load(1, 5, 1, 0, 0, 0);
    run("class1", 1'b0, 1, 120, 25, 0);
    load(1, 1, 5, 0, 0, 0);
    run("class2", 1'b0, 2, 120, 25, 0);
  endtask

  task automatic test_mid_reset();
    bit any_done;
    any_done = 1'b0;
    @(negedge clk);
    start_a = 1'b1;
    @(negedge clk);
    start_a = 1'b0;
    repeat (4) begin
      @(negedge clk);
      any_done |= done_a;
    end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_idle_zero("mid_reset_outputs");
    repeat (30) begin
      @(negedge clk);
      any_done |= done_a;
    end
    n_checks++;
    if (any_done !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_reset_no_done: got done pulse want none");
    end
    load(1, 5, 1, 0, 0, 0);
    run("after_reset", 1'b0, 1, 120, 25, 0);
  endtask

  task automatic test_tie();
    load(2, 2, 2, 0, 0, 0);
    run("tie", 1'b0, 0, 48, 25, 0);
  endtask

  task automatic test_negative();
    load(-3, -1, -2, 0, 0, 0);
    run("negative", 1'b0, 1, -24, 25, 0);
  endtask

  task automatic test_bias();
    load(1, 1, 1, 0, 0, 7);
    run("bias", 1'b1, 2, 31, 28, 0);
    n_checks++;
    if (addr_log.size() != 21 || addr_log[6] != 18 || addr_log[20] != 20) begin
      n_fail++;
      $display("FAIL bias_addr: got n=%0d a6=%0d a20=%0d want n=21 a6=18 a20=20",
               addr_log.size(), addr_log.size() > 6 ? addr_log[6] : -1,
               addr_log.size() > 20 ? addr_log[20] : -1);
    end
  endtask

  task automatic test_back_to_back();
    int extra;
    load(5, 1, 1, 0, 0, 0);
    run("busy_start", 1'b0, 0, 120, 25, 3);
    extra = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_a) extra++;
    end
    n_checks++;
    if (extra != 0) begin
      n_fail++;
      $display("FAIL busy_start_extra_done: got %0d want 0", extra);
    end
  endtask

  task automatic test_addr_layout();
    load(1, 1, 5, 0, 0, 0);
    run("layout", 1'b0, 2, 120, 25, 0);
    n_checks++;
    if (addr_log.size() != 18) begin
      n_fail++;
      $display("FAIL layout_count: got %0d want 18", addr_log.size());
    end
    for (int i = 0; i < addr_log.size() && i < 18; i++) begin
      n_checks++;
      if (addr_log[i] != i) begin
        n_fail++;
        $display("FAIL layout_addr[%0d]: got %0d want %0d", i, addr_log[i], i);
      end
    end
  endtask

  initial begin
    load(0, 0, 0, 0, 0, 0);
    test_reset();
    test_argmax();
    test_mid_reset();
    test_tie();
    test_negative();
    test_bias();
    test_back_to_back();
    test_addr_layout();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/dense_argmax_engine.md
Name: dense_argmax_engine

Overview:
Parametrised fully-connected classifier stage that sits after the Conv1D feature stage in cnn_top. It reads IN_FEATURES signed features and a class-major signed weight matrix, plus an optional per-class bias, through two registered-BRAM read ports. It accumulates one dot product per class and tracks the running maximum, then outputs the winning class index and its score. It generalises the fixed 6x3 dense/argmax path to arbitrary feature count, class count, widths and optional bias, with a defined tie rule.

Parameters:
IN_FEATURES, 6, number of features per class dot product (>=1)
NUM_CLASSES, 3, number of output classes (>=2)
FEAT_W, 24, signed feature width
WEIGHT_W, 8, signed weight/bias width
USE_BIAS, 0, 1 = add bias word per class stored after the weight matrix
ACC_W, 40, signed accumulator width; must be >= FEAT_W+WEIGHT_W+clog2(IN_FEATURES+1)
FEAT_AW, 5, feature BRAM address width
W_AW, 6, weight BRAM address width
CLS_W, 2, class index width, clog2(NUM_CLASSES)

Ports:
clk  in  1  clock
rst  in  1  reset
start  in  1  one-cycle run request; sampled only in IDLE
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when class_out/max_score are updated
feat_rd_en  out  1  feature BRAM read enable
feat_rd_addr  out  FEAT_AW  feature index k
feat_rd_data  in  FEAT_W  feature data, valid one cycle after address
w_rd_en  out  1  weight BRAM read enable
w_rd_addr  out  W_AW  weight address
w_rd_data  in  WEIGHT_W  weight data, valid one cycle after address
class_out  out  CLS_W  winning class index
max_score  out  ACC_W  winning accumulated score

Behaviour:
- Interface: one clock; reset is synchronous and active-high.
- Reset: busy=0, done=0, feat_rd_en=0, w_rd_en=0, addresses=0, class_out=0, max_score=0; FSM goes to IDLE.
- Memory layout:
  - weight for class c, feature k at w_rd_addr = c*IN_FEATURES+k.
  - bias for class c at NUM_CLASSES*IN_FEATURES+c.
  - features at feat_rd_addr = k.
- FSM states and transitions:
  - IDLE: on start=1, set c=0, k=0, clear acc and best_valid; go to FETCH.
  - FETCH: assert both read enables and issue (k, c*IN_FEATURES+k), one pair per cycle, for k=0..IN_FEATURES-1.
    - If USE_BIAS, issue one further cycle with w_rd_addr = bias address. feat_rd_en=0 in that cycle; the bias is sign-extended and added as-is.
    - Then go to DRAIN.
  - Data path during FETCH/DRAIN: each returned pair is multiplied signed and sign-extended to ACC_W, then accumulated on the cycle data arrives.
  - DRAIN: one cycle to absorb the last returned pair; read enables low; go to CMP.
  - CMP: if !best_valid or acc > best_score (strictly greater), set best_score=acc, best_idx=c. Clear acc.
    - If c==NUM_CLASSES-1, go to DONE; else c++, k=0, go to FETCH.
  - DONE: register class_out=best_idx and max_score=best_score; pulse done; busy=0 next cycle; go to IDLE.
- Latency: per class IN_FEATURES+USE_BIAS+2 cycles. done is asserted NUM_CLASSES*(IN_FEATURES+USE_BIAS+2)+1 cycles after the start-sampling edge (defaults: 25).
- Ties: the lowest class index wins (strict > compare).
- Arithmetic is two's complement throughout; no saturation. The ACC_W constraint guarantees no overflow.
- start while busy: ignored; no restart, no queueing.
- start in the same cycle as DONE: ignored (FSM is not in IDLE).
- rst mid-run: immediate return to IDLE; no done pulse; outputs cleared to reset values.
- class_out and max_score hold their values between runs; they change only in DONE or on reset.
- BRAM contents must be stable while busy. Writes during a run are outside this block's contract.

Decomposition:
- Shared package cnn_pkg:
  - FSM state localparams (IDLE, FETCH, DRAIN, CMP, DONE).
  - clog2 function.
  - Default width constants (FEAT_W, WEIGHT_W, ACC_W) shared with the conv1d stage.
- Sub-module argmax_tracker: holds best_score, best_idx and best_valid, with inputs clr, cmp_en, score and idx. Keeps the compare/tie rule isolated and reusable.
- The MAC stays inline.

Test Plan:
- All 8 conv inputs = 1, conv weights [1,2,1], so the 6 features = 4. Class 0 weights = 5, others = 1 -> class_out=0, max_score=120, done 25 cycles after start. Repeat with the high weight on class 1 and then class 2 -> class_out=1 and 2, max_score=120 each.
- All weights = 2, features = 4 (three-way tie) -> class_out=0, max_score=48.
- Features = 4; weights class0=-3, class1=-1, class2=-2 -> class_out=1, max_score=-24 (signed compare).
- USE_BIAS=1, all weights = 1, features = 4, biases [0,0,7] -> class_out=2, max_score=31, done 28 cycles after start.
- Assert rst 5 cycles into a run -> no done pulse, outputs 0. A fresh start afterwards completes normally with correct results.
- Pulse start again while busy -> ignored; exactly one done pulse at the original cycle count.
- Check that w_rd_addr follows the layout (0..5, 6..11, 12..17).
